// File: rtl/multi_cnt.sv
// Multi-channel up/down counter with per-channel load, wrap/saturate
// boundary handling, optional carry cascade between adjacent channels,
// registered terminal-count pulses and a snapshot register for all channels.
module multi_cnt #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int CASCADE  = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          en,
    input  logic [CHANNELS-1:0]          dir,
    input  logic [CHANNELS-1:0]          load,
    input  logic [CHANNELS*WIDTH-1:0]    load_value,
    input  logic                         sat_mode,
    input  logic                         snap,
    output logic [CHANNELS*WIDTH-1:0]    cnt_value,
    output logic [CHANNELS-1:0]          tc,
    output logic [CHANNELS*WIDTH-1:0]    snap_value,
    output logic                         snap_valid
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [CHANNELS-1:0] step;
    logic [CHANNELS-1:0] carry;
    logic [CHANNELS-1:0] at_bound;
    logic                carry_in;

    // Step requests and same-cycle carry chain; in cascade mode a channel
    // only steps when its lower neighbour produces a carry/borrow.
    always_comb begin
        step     = '0;
        carry    = '0;
        at_bound = '0;
        carry_in = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            at_bound[k] = dir[k] ? (cnt_value[k*WIDTH +: WIDTH] == MAX_VAL)
                                 : (cnt_value[k*WIDTH +: WIDTH] == '0);
            if (CASCADE == 0 || k == 0) begin
                step[k] = en[k];
            end else begin
                step[k] = en[k] & carry_in;
            end
            // Carry still fires while pinned in saturate mode so the next
            // channel keeps advancing.
            carry[k] = step[k] & ~load[k] & at_bound[k];
            carry_in = carry[k];
        end
    end

    // Counter update per channel: load beats step beats hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_value <= '0;
            tc        <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (load[k]) begin
                    cnt_value[k*WIDTH +: WIDTH] <= load_value[k*WIDTH +: WIDTH];
                end else if (step[k] && !(at_bound[k] && sat_mode)) begin
                    if (dir[k]) begin
                        cnt_value[k*WIDTH +: WIDTH] <= cnt_value[k*WIDTH +: WIDTH] + ONE;
                    end else begin
                        cnt_value[k*WIDTH +: WIDTH] <= cnt_value[k*WIDTH +: WIDTH] - ONE;
                    end
                end
            end
            tc <= carry;
        end
    end

    // Snapshot captures the pre-edge count; valid pulses once per request.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_value <= '0;
            snap_valid <= 1'b0;
        end else begin
            if (snap) begin
                snap_value <= cnt_value;
            end
            snap_valid <= snap;
        end
    end

endmodule

// File: tb/tb_multi_cnt.sv
// Bench for multi_cnt: a plain-wrap instance and a cascade instance driven
// with the same inputs, each compared every cycle to an integer model, plus
// directed scenarios with hand-derived expectations.
module tb_multi_cnt;

    localparam int W    = 8;
    localparam int CH   = 2;
    localparam int MAXV = 255;
    localparam int OW   = 1 + CH*W + CH + CH*W;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   en, dir, load;
    logic [CH*W-1:0] load_value;
    logic            sat_mode, snap;

    logic [CH*W-1:0] cnt_a, snapv_a, cnt_b, snapv_b;
    logic [CH-1:0]   tc_a, tc_b;
    logic            sv_a, sv_b;

    int n_checks = 0;
    int n_pass   = 0;

    // model state: index 0 = independent instance, 1 = cascade instance
    int m_cnt [2][CH];
    int m_tc  [2][CH];
    int m_snap[2][CH];
    int m_sv  [2];

    logic [OW-1:0] exp_q0[$];
    logic [OW-1:0] exp_q1[$];

    multi_cnt #(.WIDTH(W), .CHANNELS(CH), .CASCADE(0)) dut_a (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
        .load_value(load_value), .sat_mode(sat_mode), .snap(snap),
        .cnt_value(cnt_a), .tc(tc_a), .snap_value(snapv_a), .snap_valid(sv_a)
    );

    multi_cnt #(.WIDTH(W), .CHANNELS(CH), .CASCADE(1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
        .load_value(load_value), .sat_mode(sat_mode), .snap(snap),
        .cnt_value(cnt_b), .tc(tc_b), .snap_value(snapv_b), .snap_valid(sv_b)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: counters as plain integers, boundaries decided with arithmetic.
    task automatic model_edge(input int c, output logic [OW-1:0] e);
        int carry_prev;
        int step_req;
        int at_b;
        int carry;
        carry_prev = 0;
        if (rst) begin
            for (int k = 0; k < CH; k++) begin
                m_cnt[c][k] = 0; m_tc[c][k] = 0; m_snap[c][k] = 0;
            end
            m_sv[c] = 0;
        end else begin
            if (snap) begin
                for (int k = 0; k < CH; k++) m_snap[c][k] = m_cnt[c][k];
            end
            m_sv[c] = snap ? 1 : 0;
            for (int k = 0; k < CH; k++) begin
                carry = 0;
                step_req = (en[k] && (c == 0 || k == 0 || carry_prev == 1)) ? 1 : 0;
                if (load[k]) begin
                    m_cnt[c][k] = int'(load_value[k*W +: W]);
                end else if (step_req == 1) begin
                    at_b  = dir[k] ? (m_cnt[c][k] == MAXV) : (m_cnt[c][k] == 0);
                    carry = at_b;
                    if (!(at_b == 1 && sat_mode)) begin
                        if (dir[k]) m_cnt[c][k] = (m_cnt[c][k] + 1) % (MAXV + 1);
                        else        m_cnt[c][k] = (m_cnt[c][k] + MAXV) % (MAXV + 1);
                    end
                end
                m_tc[c][k] = carry;
                carry_prev = carry;
            end
        end
        e = '0;
        for (int k = 0; k < CH; k++) begin
            e[k*W +: W]         = W'(m_cnt[c][k]);
            e[CH*W + k]         = (m_tc[c][k] != 0);
            e[CH*W + CH + k*W +: W] = W'(m_snap[c][k]);
        end
        e[OW-1] = (m_sv[c] != 0);
    endtask

    // One clock: predict both instances, advance, then score the outputs.
    task automatic tick();
        logic [OW-1:0] e0, e1;
        model_edge(0, e0); exp_q0.push_back(e0);
        model_edge(1, e1); exp_q1.push_back(e1);
        @(posedge clk);
        #1;
        e0 = exp_q0.pop_front();
        e1 = exp_q1.pop_front();
        check("a_cnt",   64'(cnt_a),   64'(e0[CH*W-1:0]));
        check("a_tc",    64'(tc_a),    64'(e0[CH*W +: CH]));
        check("a_snap",  64'(snapv_a), 64'(e0[CH*W+CH +: CH*W]));
        check("a_sv",    64'(sv_a),    64'(e0[OW-1]));
        check("b_cnt",   64'(cnt_b),   64'(e1[CH*W-1:0]));
        check("b_tc",    64'(tc_b),    64'(e1[CH*W +: CH]));
        check("b_snap",  64'(snapv_b), 64'(e1[CH*W+CH +: CH*W]));
        check("b_sv",    64'(sv_b),    64'(e1[OW-1]));
    endtask

    task automatic idle_inputs();
        en = '0; dir = '0; load = '0; load_value = '0; sat_mode = 1'b0; snap = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [W-1:0] pick_lv();
        case ($urandom_range(0, 4))
            0: return 8'h00;
            1: return 8'h01;
            2: return 8'hFE;
            3: return 8'hFF;
            default: return W'($urandom_range(0, MAXV));
        endcase
    endfunction

    initial begin
        int tc_seen;
        logic [7:0] exp34 [5];
        logic       tc34  [5];
        exp34 = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        tc34  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        check("rst_cnt",  64'(cnt_a),   64'h0);
        check("rst_tc",   64'(tc_a),    64'h0);
        check("rst_snap", 64'(snapv_a), 64'h0);
        check("rst_sv",   64'(sv_a),    64'h0);

        // full up-count wrap on both channels
        en = 2'b11; dir = 2'b11;
        tc_seen = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (tc_a != 2'b00) tc_seen++;
            if (i == 254) check("wrap_pre_ff", 64'(cnt_a), 64'hFFFF);
        end
        check("wrap_cnt",   64'(cnt_a), 64'h0000);
        check("wrap_tc",    64'(tc_a),  64'h3);
        check("wrap_tc_n",  64'(tc_seen), 64'd1);
        check("casc_ch1_1", 64'(cnt_b), 64'h0100);

        // saturating count-down from 0x02
        do_reset();
        load = 2'b01; load_value = 16'h0002;
        tick();
        load = 2'b00; sat_mode = 1'b1; dir = 2'b00; en = 2'b01;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("sat_cnt", 64'(cnt_a[7:0]), 64'(exp34[i]));
            check("sat_tc",  64'(tc_a[0]),    64'(tc34[i]));
        end

        // cascade over 512 cycles
        do_reset();
        en = 2'b11; dir = 2'b11;
        tc_seen = 0;
        for (int i = 0; i < 512; i++) begin
            tick();
            if (tc_b[1]) tc_seen++;
            if (i == 255) check("casc_256", 64'(cnt_b), 64'h0100);
        end
        check("casc_512",  64'(cnt_b),   64'h0200);
        check("casc_tc1",  64'(tc_seen), 64'd0);

        // load + snap on the same edge
        do_reset();
        load = 2'b01; load_value = 16'h0010;
        tick();
        load = 2'b01; load_value = 16'h00A5; en = 2'b01; dir = 2'b01; snap = 1'b1;
        tick();
        check("ls_cnt",  64'(cnt_a[7:0]),   64'hA5);
        check("ls_snap", 64'(snapv_a[7:0]), 64'h10);
        check("ls_sv",   64'(sv_a),         64'h1);
        check("ls_tc",   64'(tc_a[0]),      64'h0);
        idle_inputs();
        tick();
        check("ls_sv_drop", 64'(sv_a),         64'h0);
        check("ls_hold",    64'(snapv_a[7:0]), 64'h10);

        // reset mid-run overrides load and snap
        load = 2'b01; load_value = 16'h0036;
        tick();
        load = 2'b00; en = 2'b01; dir = 2'b01;
        tick();
        check("mid_cnt", 64'(cnt_a[7:0]), 64'h37);
        rst = 1'b1; load = 2'b01; load_value = 16'h5A5A; snap = 1'b1;
        tick();
        check("ovr_cnt",  64'(cnt_a),   64'h0);
        check("ovr_snap", 64'(snapv_a), 64'h0);
        check("ovr_sv",   64'(sv_a),    64'h0);
        check("ovr_tc",   64'(tc_a),    64'h0);
        rst = 1'b0; load = 2'b00; snap = 1'b0;
        tick();
        check("resume", 64'(cnt_a[7:0]), 64'h01);

        // direction toggling around zero
        do_reset();
        en = 2'b01;
        for (int i = 0; i < 4; i++) begin
            dir = (i % 2 == 0) ? 2'b00 : 2'b01;
            tick();
            check("tog_cnt", 64'(cnt_a[7:0]), (i % 2 == 0) ? 64'hFF : 64'h00);
            check("tog_tc",  64'(tc_a[0]),    64'h1);
        end

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 99) == 0);
            en   = CH'($urandom_range(0, 3)) | CH'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) dir = CH'($urandom_range(0, 3));
            load = '0;
            for (int k = 0; k < CH; k++) begin
                load[k] = ($urandom_range(0, 15) == 0);
                load_value[k*W +: W] = pick_lv();
            end
            if ($urandom_range(0, 31) == 0) sat_mode = ~sat_mode;
            snap = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_cnt.md
MULTI_CNT -- requirements
Module: multi_cnt

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the bit width of each channel counter; legal range 2..32.
REQ-002 The block SHALL have parameter CHANNELS, default 2, giving the number of independent counter channels; legal range 1..8.
REQ-003 The block SHALL have parameter CASCADE, default 0; when 1, channel k>0 advances only on the carry/borrow of channel k-1.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 en  input  CHANNELS  per-channel count enable.
REQ-007 dir  input  CHANNELS  per-channel direction: 1 = up, 0 = down.
REQ-008 load  input  CHANNELS  per-channel synchronous load strobe.
REQ-009 load_value  input  CHANNELS*WIDTH  load data; channel k in bits [k*WIDTH +: WIDTH].
REQ-010 sat_mode  input  1  boundary mode for all channels: 1 = saturate, 0 = wrap.
REQ-011 snap  input  1  capture request for all channel values.
REQ-012 cnt_value  output  CHANNELS*WIDTH  registered per-channel count, same packing as load_value.
REQ-013 tc  output  CHANNELS  registered per-channel terminal-count pulse.
REQ-014 snap_value  output  CHANNELS*WIDTH  registered snapshot of cnt_value.
REQ-015 snap_valid  output  1  one-cycle pulse marking new snap_value.

Function
REQ-016 Per-channel step request: step[k] = en[k] when CASCADE=0 or k=0; step[k] = en[k] & carry[k-1] when CASCADE=1 and k>0.
REQ-017 carry[k] is combinational, same-cycle: step[k] & ~load[k] & (dir[k] ? cnt==2^WIDTH-1 : cnt==0).
REQ-018 Priority per channel per edge: load > step > hold.
REQ-019 load[k]=1: cnt[k] <= load_value[k] next edge, regardless of en, dir, carry-in; tc[k] <= 0.
REQ-020 Step, not at boundary: cnt <= cnt+1 (up) or cnt-1 (down), modulo 2^WIDTH arithmetic, latency 1 cycle.
REQ-021 Step at boundary, sat_mode=0: up wraps 2^WIDTH-1 -> 0, down wraps 0 -> 2^WIDTH-1.
REQ-022 Step at boundary, sat_mode=1: cnt holds at 2^WIDTH-1 (up) or 0 (down).
REQ-023 tc[k] SHALL be 1 in the cycle after an edge on which carry[k]=1, else 0; in saturate mode tc repeats each cycle a step is requested at the boundary.
REQ-024 In cascade with sat_mode=1, carry[k] still propagates while channel k is pinned, so channel k+1 keeps advancing.
REQ-025 Direction change takes effect on the same edge it is sampled; no pipeline state depends on previous dir.
REQ-026 snap=1: snap_value <= current (pre-update) cnt_value on that edge; snap_valid <= 1 for exactly one cycle; snap_value holds otherwise.
REQ-027 snap coincident with load or step: snapshot holds the pre-edge value, never the loaded/stepped value.
REQ-028 Back-to-back snap: snap_valid stays high each cycle, snap_value updates each cycle.
REQ-029 Channels with CASCADE=0 SHALL be fully independent; no input of channel j affects channel k.

Reset
REQ-030 rst=1 at an edge: cnt_value, tc, snap_value SHALL be all-zero and snap_valid 0 after that edge.
REQ-031 rst SHALL override load, step and snap on the same edge.
REQ-032 After rst deasserts, first update occurs on the next edge with rst=0; no extra idle cycle.

Verification
REQ-033 WIDTH=8, CHANNELS=2, CASCADE=0, sat_mode=0, en=2'b11, dir=2'b11 from reset, 256 cycles -> both cnt return to 0x00, tc=2'b11 exactly once (cycle 256), cnt 0xFF preceding it.
REQ-034 sat_mode=1, channel 0 loaded 0x02, dir=0, en=1 for 5 cycles -> cnt 0x01, 0x00, 0x00, 0x00, 0x00; tc[0] high on cycles 3..5.
REQ-035 CASCADE=1, en=2'b11, dir=up from reset, 512 cycles -> cnt[1] increments once per 256 cycles, cnt={0x02,0x00} at end, tc[1] never asserted.
REQ-036 Channel 0 at 0x10, load=1 load_value=0xA5 en=1 snap=1 same edge -> cnt[0]=0xA5, snap_value[0]=0x10, snap_valid=1 for one cycle, tc[0]=0.
REQ-037 Counting mid-run at cnt 0x37 with load and snap asserted, rst=1 one cycle -> all outputs zero next cycle; counting resumes 0x01 on first edge after rst=0.
REQ-038 dir toggled every cycle with en=1 from 0x00, sat_mode=0 -> cnt sequence 0xFF, 0x00, 0xFF, 0x00 with tc on every cycle (dir starts 0).
